// File: rtl/lcd_bus_timer.sv
// ---------------------------------------------------------------------------
// lcd_bus_timer
// Avalon-MM slave that turns one word access into a complete HD44780 bus
// cycle: address/RS/RW setup, an LCD_E strobe, then a hold period. The
// Avalon master is stalled with waitrequest until the hold period ends.
//
// Parameters (each must be in 1..255):
//   SETUP_CYC  clk cycles from RS/RW/data valid to LCD_E rise
//   PULSE_CYC  clk cycles LCD_E is held high
//   HOLD_CYC   clk cycles after LCD_E fall before the transfer completes
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset        asynchronous, active-high reset
//   address[1:0] Avalon word address; bit0 = RW, bit1 = RS
//   read, write  Avalon requests (either one starts a transfer)
//   writedata    byte driven onto LCD_data when RW = 0
//   readdata     LCD_data captured at the end of the strobe when RW = 1
//   waitrequest  high while a request is present and not yet completing
//   LCD_E/RS/RW  registered HD44780 control pins
//   LCD_data     bidirectional HD44780 data bus
// ---------------------------------------------------------------------------
module lcd_bus_timer #(
    parameter int SETUP_CYC = 3,
    parameter int PULSE_CYC = 12,
    parameter int HOLD_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] address,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       waitrequest,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    inout  wire  [7:0] LCD_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD
    } state_t;

    // Counter reload values: each phase counts N-1 down to 0.
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;

    logic       w_request;
    logic       w_start;
    logic       w_capture;
    logic       w_complete;
    logic       w_rw_next;

    logic       r_rs;
    logic       r_rw;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;
    logic       r_e;
    logic       r_oe;

    assign w_request = read | write;

    // -----------------------------------------------------------------------
    // Next-state / counter logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_start      = 1'b0;
        w_capture    = 1'b0;
        w_complete   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_request) begin
                    w_start      = 1'b1;
                    w_cnt_next   = SETUP_LD;
                    w_state_next = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (r_cnt == 8'd0) begin
                    w_cnt_next   = PULSE_LD;
                    w_state_next = ST_PULSE;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end

            ST_PULSE: begin
                if (r_cnt == 8'd0) begin
                    // Sample the bus while LCD_E is still high, on the edge
                    // that drops it.
                    w_capture    = r_rw;
                    w_cnt_next   = HOLD_LD;
                    w_state_next = ST_HOLD;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end

            ST_HOLD: begin
                if (r_cnt == 8'd0) begin
                    w_complete   = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Bus direction of the transfer in the next cycle: taken from the
    // address on the starting edge, otherwise the latched value.
    assign w_rw_next = w_start ? address[0] : r_rw;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath and pin registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the latched write byte is reset as well; it is a handful of
        // flops, not a memory, and a known value keeps the bus deterministic.
        if (reset) begin
            r_rs    <= 1'b0;
            r_rw    <= 1'b0;
            r_wdata <= 8'h00;
            r_rdata <= 8'h00;
            r_e     <= 1'b0;
            r_oe    <= 1'b0;
        end else begin
            if (w_start) begin
                r_rs    <= address[1];
                r_rw    <= address[0];
                r_wdata <= writedata;
            end
            if (w_capture) begin
                r_rdata <= LCD_data;
            end
            // Pins are decoded from the next state so they change on the
            // same edge as the FSM, straight out of flops.
            r_e  <= (w_state_next == ST_PULSE);
            r_oe <= (w_state_next != ST_IDLE) && !w_rw_next;
        end
    end

    // Requests are only accepted in IDLE; elsewhere they just hold the stall.
    assign waitrequest = w_request & ~w_complete;

    assign readdata = r_rdata;
    assign LCD_E    = r_e;
    assign LCD_RS   = r_rs;
    assign LCD_RW   = r_rw;
    assign LCD_data = r_oe ? r_wdata : 8'hzz;

endmodule
